// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Multiplexed 7-segment display driver for DIGITS digits. A hex value is
// accepted through a valid/ready load port into a pending buffer and moved to
// the display buffer only on a frame boundary, so a scan never shows a mix of
// old and new digits. Adds per-digit decimal points, optional leading-zero
// blanking, PWM brightness and a dead cycle at the start of every digit slot
// to avoid ghosting.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load        in   load request (valid), qualifies value/dp/blank_lz
//   ready       out  pending buffer free; transfer on load && ready
//   value       in   4*DIGITS hex nibbles, nibble 0 = rightmost digit
//   dp          in   decimal point per digit, bit i = digit i
//   blank_lz    in   enable leading-zero blanking for this value
//   brightness  in   live PWM level, 0 dimmest, all-ones full
//   digits      out  digit selects (polarity per DIG_ACTIVE_HIGH)
//   segments    out  {dp,g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_HIGH)
//   frame       out  one-cycle pulse the cycle after each frame boundary
//
// Handshake: load is the valid; ready is the inverse of "pending buffer full".
// A transfer happens on any rising edge where load && ready. load while
// ready=0 is ignored and does not need to be held; ready never depends
// combinationally on load.
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int DIGITS          = 4,
    parameter int DIV             = 256,
    parameter int PWM_BITS        = 3,
    parameter int SEG_ACTIVE_HIGH = 1,
    parameter int DIG_ACTIVE_HIGH = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    output logic                  ready,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]     digits,
    output logic [7:0]            segments,
    output logic                  frame
);

    localparam int SLOT_W = $clog2(DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_HIGH != 0) ? '0 : '1;

    // Scan state
    logic [SLOT_W-1:0]   r_slot_cnt;
    logic [IDX_W-1:0]    r_idx;

    // Pending buffer
    logic                r_p_full;
    logic [4*DIGITS-1:0] r_p_value;
    logic [DIGITS-1:0]   r_p_dp;
    logic                r_p_blz;

    // Display buffer
    logic [4*DIGITS-1:0] r_d_value;
    logic [DIGITS-1:0]   r_d_dp;
    logic                r_d_blz;

    // Registered pins
    logic [DIGITS-1:0]   r_digits;
    logic [7:0]          r_segments;
    logic                r_frame;

    logic                w_slot_last;
    logic                w_fb;
    logic                w_accept;
    logic [PWM_BITS-1:0] w_phase;
    logic                w_on;
    logic [DIGITS-1:0]   w_blank_vec;
    logic [3:0]          w_nibble;
    logic                w_dp_bit;
    logic                w_blank;
    logic [DIGITS-1:0]   w_dig_raw;
    logic [7:0]          w_seg_raw;
    logic [DIGITS-1:0]   w_dig_pin;
    logic [7:0]          w_seg_pin;

    // 7-segment decode, active-high {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign w_slot_last = (r_slot_cnt == SLOT_LAST);
    assign w_fb        = w_slot_last && (r_idx == IDX_LAST);
    assign ready       = ~r_p_full;
    assign w_accept    = load && ~r_p_full;

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
            r_idx      <= '0;
        end else begin
            if (w_slot_last) begin
                r_slot_cnt <= '0;
                r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double buffer. A load that lands on the frame boundary bypasses the
    // pending buffer so it is not delayed by a whole extra frame. A full
    // pending buffer blocks loads, so bypass and promotion never collide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_full  <= 1'b0;
            r_p_value <= '0;
            r_p_dp    <= '0;
            r_p_blz   <= 1'b0;
            r_d_value <= '0;
            r_d_dp    <= '0;
            r_d_blz   <= 1'b0;
        end else begin
            if (w_accept && w_fb) begin
                r_d_value <= value;
                r_d_dp    <= dp;
                r_d_blz   <= blank_lz;
            end else if (w_accept) begin
                r_p_full  <= 1'b1;
                r_p_value <= value;
                r_p_dp    <= dp;
                r_p_blz   <= blank_lz;
            end else if (w_fb && r_p_full) begin
                r_p_full  <= 1'b0;
                r_d_value <= r_p_value;
                r_d_dp    <= r_p_dp;
                r_d_blz   <= r_p_blz;
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM: phase is the top PWM_BITS of the slot counter. Slot cycle 0 is
    // always dark so the previous digit's segments never leak into the next.
    // ------------------------------------------------------------------
    assign w_phase = r_slot_cnt[SLOT_W-1 -: PWM_BITS];
    assign w_on    = (r_slot_cnt != '0) && (w_phase <= brightness);

    // Digit i is a leading zero when it and every digit to its left are zero.
    always_comb begin
        w_blank_vec = '0;
        for (int i = 1; i < DIGITS; i++) begin
            w_blank_vec[i] = r_d_blz && ((r_d_value >> (4 * i)) == '0);
        end
    end

    always_comb begin
        w_nibble  = '0;
        w_dp_bit  = 1'b0;
        w_blank   = 1'b0;
        w_dig_raw = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble     = r_d_value[4*i +: 4];
                w_dp_bit     = r_d_dp[i];
                w_blank      = w_blank_vec[i];
                w_dig_raw[i] = w_on;
            end
        end
    end

    always_comb begin
        w_seg_raw = '0;
        if (w_on) begin
            w_seg_raw[7]   = w_dp_bit;
            w_seg_raw[6:0] = w_blank ? 7'h00 : hex_to_seg(w_nibble);
        end
    end

    assign w_dig_pin = (DIG_ACTIVE_HIGH != 0) ? w_dig_raw : ~w_dig_raw;
    assign w_seg_pin = (SEG_ACTIVE_HIGH != 0) ? w_seg_raw : ~w_seg_raw;

    // ------------------------------------------------------------------
    // Output registers: pins show the scan state of the previous cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits   <= DIG_OFF;
            r_segments <= SEG_OFF;
            r_frame    <= 1'b0;
        end else begin
            r_digits   <= w_dig_pin;
            r_segments <= w_seg_pin;
            r_frame    <= w_fb;
        end
    end

    assign digits   = r_digits;
    assign segments = r_segments;
    assign frame    = r_frame;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Bench for seven_seg_scanner with default parameters. The reference model
// derives the scan position from a cycle count since reset release, keeps the
// pending/display buffers as plain variables updated by the load rules, and
// predicts the pins from a segment lookup table. Expected pin words go into a
// queue before each clock edge and are popped and compared after it.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

  localparam int DIGITS   = 4;
  localparam int DIV      = 256;
  localparam int PWM_BITS = 3;
  localparam int SEG_AH   = 1;
  localparam int DIG_AH   = 0;
  localparam int FRAME    = DIGITS * DIV;
  localparam int SHIFT    = $clog2(DIV) - PWM_BITS;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        load;
  logic        ready;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [2:0]  brightness;
  logic [3:0]  digits;
  logic [7:0]  segments;
  logic        frame;

  seven_seg_scanner #(
    .DIGITS          (DIGITS),
    .DIV             (DIV),
    .PWM_BITS        (PWM_BITS),
    .SEG_ACTIVE_HIGH (SEG_AH),
    .DIG_ACTIVE_HIGH (DIG_AH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .ready      (ready),
    .value      (value),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .digits     (digits),
    .segments   (segments),
    .frame      (frame)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // reference model state
  int          cyc;
  bit          m_p_full;
  logic [15:0] m_p_val, m_d_val;
  logic [3:0]  m_p_dp,  m_d_dp;
  bit          m_p_blz, m_d_blz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc      = 0;
    m_p_full = 0;
    m_p_val  = '0;
    m_p_dp   = '0;
    m_p_blz  = 0;
    m_d_val  = '0;
    m_d_dp   = '0;
    m_d_blz  = 0;
    exp_q.delete();
  endtask

  // Pins {digits, segments} for scan position (slot, idx) with the current display buffer.
  function automatic logic [11:0] expected_pins(input int slot, input int idx, input int br);
    logic [3:0]  d_raw;
    logic [7:0]  s_raw;
    logic [15:0] upper;
    d_raw = '0;
    s_raw = '0;
    if (slot != 0 && (slot >> SHIFT) <= br) begin
      d_raw    = 4'(1 << idx);
      upper    = m_d_val >> (4 * idx);
      s_raw[7] = m_d_dp[idx];
      if (!(m_d_blz && idx > 0 && upper == 16'h0))
        s_raw[6:0] = seg_tbl[upper[3:0]];
    end
    return {(DIG_AH != 0) ? d_raw : ~d_raw, (SEG_AH != 0) ? s_raw : ~s_raw};
  endfunction

  // One clock: predict, apply load rules, clock, compare.
  task automatic tick();
    int         slot;
    int         idx;
    bit         fb;
    bit         acc;
    logic [11:0] pins;
    logic [31:0] e;
    slot = cyc % DIV;
    idx  = (cyc / DIV) % DIGITS;
    fb   = (slot == DIV - 1) && (idx == DIGITS - 1);
    pins = expected_pins(slot, idx, int'(brightness));
    acc  = load && !m_p_full;
    if (acc && fb) begin
      m_d_val = value; m_d_dp = dp; m_d_blz = blank_lz;
    end else if (acc) begin
      m_p_val = value; m_p_dp = dp; m_p_blz = blank_lz; m_p_full = 1;
    end else if (fb && m_p_full) begin
      m_d_val = m_p_val; m_d_dp = m_p_dp; m_d_blz = m_p_blz; m_p_full = 0;
    end
    cyc++;
    exp_q.push_back({18'b0, !m_p_full, fb, pins});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("digits",   32'(digits),   32'(e[11:8]));
    check("segments", 32'(segments), 32'(e[7:0]));
    check("frame",    32'(frame),    32'(e[12]));
    check("ready",    32'(ready),    32'(e[13]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next tick will process frame position 'pos' (bounded by one frame).
  task automatic run_to(input int pos);
    for (int i = 0; i < FRAME && (cyc % FRAME) != pos; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] disp_exp [4] = '{8'h7D, 8'h4F, 8'hCF, 8'h00};
  int on_cnt;

  initial begin
    load       = 1'b0;
    value      = '0;
    dp         = '0;
    blank_lz   = 1'b0;
    brightness = 3'd7;
    rst_n      = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits",   32'(digits),   32'h0F);
    check("rst_segments", 32'(segments), 32'h00);
    check("rst_frame",    32'(frame),    32'h0);
    check("rst_ready",    32'(ready),    32'h1);
    rst_n = 1'b1;

    // default scan: 0000 shown, full brightness
    run(FRAME + 8);

    // 0x0336 with dp on digit 2 and blanking; second load back-to-back is ignored
    run_to(300);
    value = 16'h0336; dp = 4'b0100; blank_lz = 1'b1; load = 1'b1;
    tick();
    check("ready_low_after_load", 32'(ready), 32'h0);
    value = 16'hFFFF; dp = 4'b0000; blank_lz = 1'b0;
    tick();
    load = 1'b0;
    run_to(0);
    for (int d = 0; d < DIGITS; d++) begin
      run_to(d * DIV + 100);
      tick();
      check("disp_0336", 32'(segments), 32'(disp_exp[d]));
    end

    // load exactly on the frame boundary
    run_to(FRAME - 1);
    value = 16'hABCD; dp = 4'b1001; blank_lz = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    check("ready_at_fb", 32'(ready), 32'h1);
    run(FRAME + 4);

    // PWM on-time per slot
    run_to(DIV);
    brightness = 3'd0;
    on_cnt = 0;
    for (int i = 0; i < DIV; i++) begin
      tick();
      if (digits != 4'hF) on_cnt++;
    end
    check("on_time_b0", 32'(on_cnt), 32'd31);
    brightness = 3'd3;
    on_cnt = 0;
    for (int i = 0; i < DIV; i++) begin
      tick();
      if (digits != 4'hF) on_cnt++;
    end
    check("on_time_b3", 32'(on_cnt), 32'd127);

    // randomized loads, brightness and gaps
    for (int n = 0; n < 40; n++) begin
      brightness = 3'($urandom_range(0, 7));
      run($urandom_range(0, 600));
      value    = 16'($urandom);
      if ($urandom_range(0, 1) == 1) value = value & 16'h00FF;
      if ($urandom_range(0, 3) == 0) value = 16'h0000;
      dp       = 4'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
      load     = 1'b1;
      tick();
      load     = 1'b0;
    end
    run(FRAME + 4);

    // reset mid-slot with the pending buffer full
    brightness = 3'd7;
    run_to(500);
    value = 16'h1234; dp = 4'b1111; blank_lz = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    run(20);
    check("p_full_before_reset", 32'(ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_digits",   32'(digits),   32'h0F);
    check("async_rst_segments", 32'(segments), 32'h00);
    check("async_rst_ready",    32'(ready),    32'h1);
    check("async_rst_frame",    32'(frame),    32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(FRAME + 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised multiplexed 7-segment display driver for N digits. It accepts a hex value through a valid/ready load port and double-buffers it so the display changes only on frame boundaries. It adds per-digit decimal points, optional leading-zero blanking, PWM brightness and a dead cycle between digits against ghosting. It sits between application logic and the board's common-anode/common-cathode display pins.

## Interface
- `DIGITS`, 4: number of multiplexed digits, ≥2.
- `DIV`, 256: clock cycles per digit slot; power of two, ≥ 2^`PWM_BITS`.
- `PWM_BITS`, 3: brightness resolution.
- `SEG_ACTIVE_HIGH`, 1: segment pin polarity; 1 means lit = 1.
- `DIG_ACTIVE_HIGH`, 0: digit-select polarity; 0 means selected = 0.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: load request; valid with `value`, `dp`, `blank_lz`.
- `ready` out 1: pending buffer free; a transfer occurs on `load && ready`.
- `value` in 4*`DIGITS`: hex nibbles; nibble 0 (bits 3:0) is the rightmost digit.
- `dp` in `DIGITS`: decimal point per digit; bit i belongs to digit i.
- `blank_lz` in 1: enable leading-zero blanking for this value.
- `brightness` in `PWM_BITS`: live, not buffered; 0 is dimmest, all-ones is full.
- `digits` out `DIGITS`: digit selects; bit i drives digit i.
- `segments` out 8: {dp,g,f,e,d,c,b,a}.
- `frame` out 1: one-cycle pulse at the end of each full scan.

## Operation
- Scan state:
  - `slot_cnt` counts 0..`DIV`-1.
  - `idx` counts 0..`DIGITS`-1. It advances when `slot_cnt`==`DIV`-1 and wraps from `DIGITS`-1 to 0.
- Frame boundary (FB): the cycle with `slot_cnt`==`DIV`-1 and `idx`==`DIGITS`-1. `frame`=1 in the cycle after FB, for exactly one cycle.
- Buffering: pending register (P) plus display register (D).
  - On `load && ready`, P captures {value, dp, blank_lz} and `ready` drops.
  - At FB with P full, D ← P and `ready` rises the next cycle.
  - If `load && ready` coincides with FB, the new data goes straight into D and `ready` stays 1.
  - `load` while `ready`=0 is ignored. P is never overwritten.
- Decode: full hex 0–F.
  - a–g for 0–9 use the standard patterns (e.g. 0 → 0x3F, 8 → 0x7F, 3 → 0x4F).
  - A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71. These values are active-high, before polarity is applied.
- Leading-zero blanking: digit i (i≥1) is blanked when D.blank_lz=1 and nibbles i..`DIGITS`-1 are all zero.
  - A blanked digit shows a–g off; its dp bit is still shown.
  - Digit 0 is never blanked.
- Brightness: let `phase` = `slot_cnt` >> (log2(`DIV`)-`PWM_BITS`). The current digit is selected when `slot_cnt`≠0 and `phase` ≤ `brightness`.
  - `slot_cnt`==0 is the dead cycle: no digit selected.
  - When no digit is selected, segments are driven inactive.
- Polarity: the active level of each output is applied by its parameter. "Inactive" means all bits at the off level.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `slot_cnt`=0, `idx`=0, D=0, P empty.
  - `ready`=1, `frame`=0.
  - `digits` all inactive, `segments` all inactive.
- `digits`, `segments` and `frame` are registered: they reflect the scan state one cycle later. No combinational path from input to output.
- Load-to-display latency: from 1 cycle (coincides with FB) up to `DIGITS`*`DIV` cycles plus 1.
- `brightness` change takes effect on the next cycle's compare.
- Reset mid-frame clears P and D immediately. A load accepted before reset is lost.
- Digit-on time per slot at `brightness`=b is (b+1)*`DIV`/2^`PWM_BITS` − 1 cycles when b=0 … the dead cycle is always subtracted.

## Test plan
- Reset, then run 4*256 cycles with defaults → `digits` cycle 1110, 1101, 1011, 0111 with 256-cycle slots; `segments`=0x3F during selected cycles; `frame` pulses every 1024 cycles.
- Load `value`=0x0336, `dp`=0100, `blank_lz`=1, `brightness`=7 → after the next FB, digits 0..3 show 0x7D, 0x4F, 0xCF, 0x00; `ready` low until that FB.
- Load twice back-to-back mid-frame → second `load` ignored (`ready`=0); first value displayed after FB; `ready`=1 the cycle after.
- Load asserted exactly at the FB cycle → `ready` never drops; new value visible from the first slot of the next frame.
- `brightness`=0 → each digit selected only for `slot_cnt` 1..31 (31 cycles per slot); `brightness`=3 → `slot_cnt` 1..127.
- Assert `rst_n`=0 mid-slot with P full → outputs inactive in the same cycle (asynchronous); after release `ready`=1 and the display shows 0000.
